// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag layout for the sequential ALU.
// Flags are packed as {N,Z,C,V}.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUMA  = 4'd0,
        OP_RESTA = 4'd1,
        OP_MULT  = 4'd2,
        OP_DIV   = 4'd3,
        OP_MOD   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CALC   = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam int IDX_N = 3;
    localparam int IDX_Z = 2;
    localparam int IDX_C = 1;
    localparam int IDX_V = 0;

    function automatic logic [3:0] armarBanderas(input logic n, input logic z,
                                                 input logic c, input logic v);
        logic [3:0] b;
        b        = '0;
        b[IDX_N] = n;
        b[IDX_Z] = z;
        b[IDX_C] = c;
        b[IDX_V] = v;
        return b;
    endfunction

    function automatic logic esIterativa(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_secuencial_unidad.sv
// Shared shift-register datapath: shift-add multiply and restoring divide.
// One iteration happens on the start edge itself, so ANCHO iterations end ANCHO-1 cycles later.
module unidad_iterativa #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arranque,
    input  logic             modo,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic [ANCHO-1:0] productoCociente,
    output logic [ANCHO-1:0] resto,
    output logic             hecho
);

    localparam int CW = $clog2(ANCHO) + 1;

    // alto: accumulator (mult) or partial remainder (div); bajo: multiplier / quotient.
    logic [ANCHO-1:0] alto, bajo, operando;
    logic             esMult;
    logic [CW-1:0]    iter;

    logic [ANCHO-1:0] altoAct, bajoAct, opAct, diferencia, altoSig, bajoSig;
    logic [ANCHO:0]   suma, desp;
    logic             multAct, cabe, activo;

    always_comb begin
        multAct    = arranque ? modo : esMult;
        altoAct    = arranque ? '0 : alto;
        bajoAct    = arranque ? (modo ? b : a) : bajo;
        opAct      = arranque ? (modo ? a : b) : operando;
        suma       = {1'b0, altoAct} + (bajoAct[0] ? {1'b0, opAct} : '0);
        desp       = {altoAct, bajoAct[ANCHO-1]};
        cabe       = desp >= {1'b0, opAct};
        // Remainder always fits in ANCHO bits, so the truncated subtraction is exact.
        diferencia = desp[ANCHO-1:0] - opAct;
        if (multAct) begin
            altoSig = suma[ANCHO:1];
            bajoSig = {suma[0], bajoAct[ANCHO-1:1]};
        end else begin
            altoSig = cabe ? diferencia : desp[ANCHO-1:0];
            bajoSig = {bajoAct[ANCHO-2:0], cabe};
        end
    end

    assign activo = (iter != '0) && (iter != CW'(ANCHO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alto     <= '0;
            bajo     <= '0;
            operando <= '0;
            esMult   <= 1'b0;
            iter     <= '0;
        end else if (arranque) begin
            alto     <= altoSig;
            bajo     <= bajoSig;
            operando <= opAct;
            esMult   <= modo;
            iter     <= CW'(1);
        end else if (activo) begin
            alto <= altoSig;
            bajo <= bajoSig;
            iter <= iter + CW'(1);
        end
    end

    assign productoCociente = bajo;
    assign resto            = alto;
    assign hecho            = (iter == CW'(ANCHO));

endmodule

// File: rtl/alu_secuencial.sv
// Multi-cycle ALU: start/busy/done handshake, registered result and {N,Z,C,V} flags.
// Single-cycle ops finish at the accept edge; mult/div/mod run ANCHO cycles in unidad_iterativa.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [ANCHO-1:0] operandoA,
    input  logic [ANCHO-1:0] operandoB,
    input  logic [3:0]       seleccion,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] resultado,
    output logic [3:0]       banderas
);

    localparam int            CW     = $clog2(ANCHO) + 1;
    localparam int            MSB    = ANCHO - 1;
    localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

    estado_t          estado;
    logic [CW-1:0]    cuenta;
    logic [3:0]       opReg;
    logic             divCero;

    logic [ANCHO-1:0] resSimple, resIter, prodCoc, resto;
    logic             cSimple, vSimple, vIter, hecho, arranque;
    logic [ANCHO:0]   sumaExt, izq, der;
    logic [31:0]      cantidad;

    assign arranque = (estado == REPOSO) && inicio && esIterativa(seleccion);

    unidad_iterativa #(.ANCHO(ANCHO)) uIter (
        .clk             (clk),
        .rst             (rst),
        .arranque        (arranque),
        .modo            (seleccion == OP_MULT),
        .a               (operandoA),
        .b               (operandoB),
        .productoCociente(prodCoc),
        .resto           (resto),
        .hecho           (hecho)
    );

    always_comb begin
        resSimple = '0;
        cSimple   = 1'b0;
        vSimple   = 1'b0;
        cantidad  = 32'(operandoB);
        sumaExt   = {1'b0, operandoA} + {1'b0, operandoB};
        // Extra bit on the shifted-out side captures the last bit lost.
        izq       = {1'b0, operandoA} << cantidad;
        der       = {operandoA, 1'b0} >> cantidad;
        case (seleccion)
            OP_SUMA: begin
                resSimple = sumaExt[MSB:0];
                cSimple   = sumaExt[ANCHO];
                vSimple   = (operandoA[MSB] == operandoB[MSB]) && (sumaExt[MSB] != operandoA[MSB]);
            end
            OP_RESTA: begin
                resSimple = operandoA - operandoB;
                cSimple   = operandoA < operandoB;
                vSimple   = (operandoA[MSB] != operandoB[MSB]) && (resSimple[MSB] != operandoA[MSB]);
            end
            OP_AND: resSimple = operandoA & operandoB;
            OP_OR:  resSimple = operandoA | operandoB;
            OP_XOR: resSimple = operandoA ^ operandoB;
            OP_SHL: begin
                if (cantidad == 0) begin
                    resSimple = operandoA;
                end else if (cantidad < ANCHO) begin
                    resSimple = izq[MSB:0];
                    cSimple   = izq[ANCHO];
                end
            end
            OP_SHR: begin
                if (cantidad == 0) begin
                    resSimple = operandoA;
                end else if (cantidad < ANCHO) begin
                    resSimple = der[ANCHO:1];
                    cSimple   = der[0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        resIter = resto;
        vIter   = divCero;
        case (opReg)
            OP_MULT: begin
                resIter = prodCoc;
                vIter   = |resto;
            end
            OP_DIV:  resIter = prodCoc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= REPOSO;
            cuenta    <= '0;
            opReg     <= '0;
            divCero   <= 1'b0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            resultado <= '0;
            banderas  <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    listo <= 1'b0;
                    if (inicio) begin
                        opReg   <= seleccion;
                        divCero <= (operandoB == '0);
                        cuenta  <= '0;
                        if (esIterativa(seleccion)) begin
                            estado  <= CALC;
                            ocupado <= 1'b1;
                        end else begin
                            estado    <= FIN;
                            listo     <= 1'b1;
                            resultado <= resSimple;
                            banderas  <= armarBanderas(resSimple[MSB], resSimple == '0, cSimple, vSimple);
                        end
                    end
                end
                CALC: begin
                    cuenta <= cuenta + CW'(1);
                    if (cuenta == ULTIMA && hecho) begin
                        estado    <= FIN;
                        ocupado   <= 1'b0;
                        listo     <= 1'b1;
                        resultado <= resIter;
                        banderas  <= armarBanderas(resIter[MSB], resIter == '0, 1'b0, vIter);
                    end
                end
                FIN: begin
                    // listo is high for this cycle only; any inicio seen here is dropped.
                    listo  <= 1'b0;
                    estado <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial: ANCHO=4 instance for the opcode table, ANCHO=8 for width scaling.
module tb_alu_secuencial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       inicio4, ocupado4, listo4;
    logic [3:0] a4, b4, sel4, res4, ban4;
    logic       inicio8, ocupado8, listo8;
    logic [7:0] a8, b8, res8;
    logic [3:0] sel8, ban8;

    int checks  = 0;
    int errores = 0;

    alu_secuencial #(.ANCHO(4)) dut4 (
        .clk(clk), .rst(rst), .inicio(inicio4), .operandoA(a4), .operandoB(b4),
        .seleccion(sel4), .ocupado(ocupado4), .listo(listo4), .resultado(res4), .banderas(ban4)
    );

    alu_secuencial #(.ANCHO(8)) dut8 (
        .clk(clk), .rst(rst), .inicio(inicio8), .operandoA(a8), .operandoB(b8),
        .seleccion(sel8), .ocupado(ocupado8), .listo(listo8), .resultado(res8), .banderas(ban8)
    );

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Issue one request and wait (bounded) for listo; latency counted in cycles after the accept edge.
    task automatic operar(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          output logic [7:0] r, output logic [3:0] f, output int lat, output int ocup);
        @(negedge clk);
        if (w8) begin
            a8 = a; b8 = b; sel8 = op; inicio8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; sel4 = op; inicio4 = 1'b1;
        end
        @(posedge clk);
        #1;
        inicio4 = 1'b0;
        inicio8 = 1'b0;
        lat = 0; ocup = 0; r = '0; f = '0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (w8 ? listo8 : listo4) begin
                r = w8 ? res8 : {4'b0, res4};
                f = w8 ? ban8 : ban4;
                break;
            end
            if (w8 ? ocupado8 : ocupado4) ocup++;
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, r;
        logic [3:0] f;
        int         lat;
    } vec_t;

    vec_t tabla[$];

    task automatic agregar(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic [3:0] f, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.f = f; v.lat = lat;
        tabla.push_back(v);
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        int         lat, ocup, pulsos;

        rst = 1'b1;
        inicio4 = 0; a4 = 0; b4 = 0; sel4 = 0;
        inicio8 = 0; a8 = 0; b8 = 0; sel8 = 0;
        repeat (3) @(negedge clk);
        verificar("rst ocupado", ocupado4, 0);
        verificar("rst listo", listo4, 0);
        verificar("rst resultado", res4, 0);
        verificar("rst banderas", ban4, 0);
        rst = 1'b0;

        //       op      a      b      r      {NZCV}   lat
        agregar(4'd0,  8'd7,  8'd9,  8'd0,  4'b0110, 1);
        agregar(4'd0,  8'd7,  8'd1,  8'd8,  4'b1001, 1);
        agregar(4'd1,  8'd3,  8'd5,  8'd14, 4'b1010, 1);
        agregar(4'd1,  8'd8,  8'd1,  8'd7,  4'b0001, 1);
        agregar(4'd2,  8'd5,  8'd6,  8'd14, 4'b1001, 5);
        agregar(4'd2,  8'd3,  8'd4,  8'd12, 4'b1000, 5);
        agregar(4'd3,  8'd13, 8'd4,  8'd3,  4'b0000, 5);
        agregar(4'd4,  8'd13, 8'd4,  8'd1,  4'b0000, 5);
        agregar(4'd3,  8'd9,  8'd0,  8'd15, 4'b1001, 5);
        agregar(4'd4,  8'd9,  8'd0,  8'd9,  4'b1001, 5);
        agregar(4'd3,  8'd7,  8'd9,  8'd0,  4'b0100, 5);
        agregar(4'd4,  8'd7,  8'd9,  8'd7,  4'b0000, 5);
        agregar(4'd3,  8'd15, 8'd3,  8'd5,  4'b0000, 5);
        agregar(4'd5,  8'd12, 8'd10, 8'd8,  4'b1000, 1);
        agregar(4'd6,  8'd12, 8'd3,  8'd15, 4'b1000, 1);
        agregar(4'd7,  8'd5,  8'd5,  8'd0,  4'b0100, 1);
        agregar(4'd8,  8'd11, 8'd1,  8'd6,  4'b0010, 1);
        agregar(4'd9,  8'd11, 8'd5,  8'd0,  4'b0100, 1);
        agregar(4'd9,  8'd11, 8'd1,  8'd5,  4'b0010, 1);
        agregar(4'd8,  8'd11, 8'd0,  8'd11, 4'b1000, 1);
        agregar(4'd8,  8'd11, 8'd4,  8'd0,  4'b0100, 1);
        agregar(4'd12, 8'd9,  8'd3,  8'd0,  4'b0100, 1);
        agregar(4'd2,  8'd15, 8'd15, 8'd1,  4'b0001, 5);

        foreach (tabla[i]) begin
            operar(1'b0, tabla[i].a, tabla[i].b, tabla[i].op, r, f, lat, ocup);
            verificar($sformatf("v%0d resultado", i), r, tabla[i].r);
            verificar($sformatf("v%0d banderas", i), f, tabla[i].f);
            verificar($sformatf("v%0d latencia", i), lat, tabla[i].lat);
            verificar($sformatf("v%0d ocupado", i), ocup, tabla[i].lat - 1);
            @(negedge clk);
            verificar($sformatf("v%0d pulso", i), listo4, 0);
        end

        // inicio held through busy and FIN, inputs changed after accept
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd6; sel4 = 4'd2; inicio4 = 1'b1;
        @(posedge clk);
        #1;
        a4 = 4'd15; b4 = 4'd15; sel4 = 4'd0;
        lat = 0; r = '0; f = '0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (listo4) begin
                r = {4'b0, res4};
                f = ban4;
                break;
            end
        end
        @(negedge clk);
        inicio4 = 1'b0;
        verificar("ruido resultado", r, 14);
        verificar("ruido banderas", f, 4'b1001);
        verificar("ruido latencia", lat, 5);
        pulsos = 0;
        repeat (8) begin
            @(negedge clk);
            if (listo4 || ocupado4) pulsos++;
        end
        verificar("ruido sin aceptar", pulsos, 0);

        // reset in the middle of a multiply
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; sel4 = 4'd2; inicio4 = 1'b1;
        @(posedge clk);
        #1;
        inicio4 = 1'b0;
        @(negedge clk);
        verificar("pre-rst ocupado", ocupado4, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        verificar("rst medio ocupado", ocupado4, 0);
        verificar("rst medio listo", listo4, 0);
        verificar("rst medio resultado", res4, 0);
        verificar("rst medio banderas", ban4, 0);
        @(negedge clk);
        rst = 1'b0;
        pulsos = 0;
        repeat (8) begin
            @(negedge clk);
            if (listo4) pulsos++;
        end
        verificar("rst medio sin listo", pulsos, 0);
        operar(1'b0, 8'd2, 8'd3, 4'd0, r, f, lat, ocup);
        verificar("post-rst resultado", r, 5);
        verificar("post-rst banderas", f, 4'b0000);

        // wider instance
        operar(1'b1, 8'd200, 8'd2, 4'd2, r, f, lat, ocup);
        verificar("w8 mult resultado", r, 144);
        verificar("w8 mult banderas", f, 4'b1001);
        verificar("w8 mult latencia", lat, 9);
        operar(1'b1, 8'd100, 8'd100, 4'd0, r, f, lat, ocup);
        verificar("w8 suma resultado", r, 200);
        verificar("w8 suma banderas", f, 4'b1001);
        operar(1'b1, 8'd200, 8'd7, 4'd4, r, f, lat, ocup);
        verificar("w8 mod resultado", r, 4);
        verificar("w8 mod latencia", lat, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errores);
        $finish;
    end

endmodule
